// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a {N,Z,F,L,C} flag register, carry-chained
// ADDC/SUBC and multi-cycle variable shifts (one bit per clock) behind a
// valid/ready handshake.
module alu_seq #(
    parameter int         WIDTH    = 16,
    parameter logic [4:0] FLAG_RST = 5'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [4:0]       OpCode,
    input  logic [WIDTH-1:0] Rsrc,
    input  logic [WIDTH-1:0] Rdest,
    output logic [WIDTH-1:0] Out,
    output logic             out_valid,
    output logic [4:0]       Flags,
    output logic             op_err
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);
    localparam logic [SHW-1:0] CNT_ZERO = '0;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_CMP   = 5'd2;
    localparam logic [4:0] OP_AND   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_NOT   = 5'd6;
    localparam logic [4:0] OP_LSH   = 5'd7;
    localparam logic [4:0] OP_RSH   = 5'd8;
    localparam logic [4:0] OP_ARSH  = 5'd9;
    localparam logic [4:0] OP_ADDC  = 5'd10;
    localparam logic [4:0] OP_SUBC  = 5'd11;
    localparam logic [4:0] OP_LSHV  = 5'd12;
    localparam logic [4:0] OP_RSHV  = 5'd13;
    localparam logic [4:0] OP_ARSHV = 5'd14;
    localparam logic [4:0] OP_MOV   = 5'd15;

    // Flag bit positions inside the PSR
    localparam int FL_N = 4;
    localparam int FL_F = 2;
    localparam int FL_C = 0;

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_out, w_out_next;
    logic               r_out_valid, w_out_valid_next;
    logic               r_op_err, w_op_err_next;
    logic [4:0]         r_flags, w_flags_next;
    logic [WIDTH-1:0]   r_shreg, w_shreg_next;
    logic [SHW-1:0]     r_cnt, w_cnt_next;
    logic [1:0]         r_sh_kind, w_sh_kind_next;

    logic               w_accept;
    logic               w_cin;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_ovf_add;
    logic               w_ovf_sub;
    logic               w_lt_u;
    logic               w_eq;
    logic               w_lt_s;
    logic [SHW-1:0]     w_amt;
    logic [WIDTH-1:0]   w_shreg_step;

    // One-bit shift step; kind is OpCode[1:0] of the variable-shift opcodes
    // (0 = logical left, 1 = logical right, 2 = arithmetic right).
    function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] kind,
                                                   input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        case (kind)
            2'd0:    res = {v[WIDTH-2:0], 1'b0};
            2'd1:    res = {1'b0, v[WIDTH-1:1]};
            default: res = {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
        return res;
    endfunction

    assign w_accept = in_valid & (r_state == S_IDLE);
    // Carry-in for ADDC and borrow-in for SUBC both come from the stored C
    assign w_cin    = ((OpCode == OP_ADDC) || (OpCode == OP_SUBC)) & r_flags[FL_C];
    assign w_sum    = {1'b0, Rdest} + {1'b0, Rsrc} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff   = {1'b0, Rdest} - {1'b0, Rsrc} - {{WIDTH{1'b0}}, w_cin};
    assign w_ovf_add = (Rdest[WIDTH-1] == Rsrc[WIDTH-1]) & (w_sum[WIDTH-1] != Rdest[WIDTH-1]);
    assign w_ovf_sub = (Rdest[WIDTH-1] != Rsrc[WIDTH-1]) & (w_diff[WIDTH-1] != Rdest[WIDTH-1]);
    assign w_lt_u   = Rdest < Rsrc;
    assign w_eq     = Rdest == Rsrc;
    assign w_lt_s   = $signed(Rdest) < $signed(Rsrc);
    assign w_amt    = Rsrc[SHW-1:0];
    assign w_shreg_step = shift_one(r_sh_kind, r_shreg);

    // Next-state, result and flag computation for both FSM states
    always_comb begin
        w_state_next     = r_state;
        w_out_next       = r_out;
        w_out_valid_next = 1'b0;
        w_op_err_next    = 1'b0;
        w_flags_next     = r_flags;
        w_shreg_next     = r_shreg;
        w_cnt_next       = r_cnt;
        w_sh_kind_next   = r_sh_kind;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_out_valid_next = 1'b1;
                    case (OpCode)
                        OP_ADD, OP_ADDC: begin
                            w_out_next   = w_sum[WIDTH-1:0];
                            w_flags_next = {w_lt_s, w_eq, w_ovf_add, w_lt_u, w_sum[WIDTH]};
                        end
                        OP_SUB, OP_SUBC: begin
                            w_out_next   = w_diff[WIDTH-1:0];
                            w_flags_next = {w_lt_s, w_eq, w_ovf_sub, w_lt_u, w_diff[WIDTH]};
                        end
                        OP_CMP:  w_flags_next = {w_lt_s, w_eq, r_flags[FL_F], w_lt_u, r_flags[FL_C]};
                        OP_AND:  w_out_next = Rdest & Rsrc;
                        OP_OR:   w_out_next = Rdest | Rsrc;
                        OP_XOR:  w_out_next = Rdest ^ Rsrc;
                        OP_NOT:  w_out_next = ~Rsrc;
                        OP_LSH:  w_out_next = {Rsrc[WIDTH-2:0], 1'b0};
                        OP_RSH:  w_out_next = {1'b0, Rsrc[WIDTH-1:1]};
                        OP_ARSH: w_out_next = {Rsrc[WIDTH-1], Rsrc[WIDTH-1:1]};
                        OP_MOV:  w_out_next = Rsrc;
                        OP_LSHV, OP_RSHV, OP_ARSHV: begin
                            if (w_amt == CNT_ZERO) begin
                                w_out_next = Rdest;
                            end else begin
                                // Multi-cycle: completion is reported from S_SHIFT
                                w_out_valid_next = 1'b0;
                                w_shreg_next     = Rdest;
                                w_cnt_next       = w_amt;
                                w_sh_kind_next   = OpCode[1:0];
                                w_state_next     = S_SHIFT;
                            end
                        end
                        default: w_op_err_next = 1'b1;
                    endcase
                end
            end
            S_SHIFT: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_shreg_next = w_shreg_step;
                    w_cnt_next   = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_out_next       = w_shreg_step;
                        w_out_valid_next = 1'b1;
                        w_state_next     = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any shift in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_op_err    <= 1'b0;
            r_flags     <= FLAG_RST;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_sh_kind   <= 2'd0;
        end else begin
            r_state     <= w_state_next;
            r_out       <= w_out_next;
            r_out_valid <= w_out_valid_next;
            r_op_err    <= w_op_err_next;
            r_flags     <= w_flags_next;
            r_shreg     <= w_shreg_next;
            r_cnt       <= w_cnt_next;
            r_sh_kind   <= w_sh_kind_next;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign Out       = r_out;
    assign out_valid = r_out_valid;
    assign Flags     = r_flags;
    assign op_err    = r_op_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: three instances (WIDTH 16, 8, 32) share the
// opcode/operand buses and are selected by their own in_valid.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [4:0]  op;
    logic [31:0] rd;
    logic [31:0] rs;
    logic [2:0]  vld;

    logic        rdy16, ov16, err16;
    logic [15:0] out16;
    logic [4:0]  fl16;
    logic        rdy8, ov8, err8;
    logic [7:0]  out8;
    logic [4:0]  fl8;
    logic        rdy32, ov32, err32;
    logic [31:0] out32;
    logic [4:0]  fl32;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy16), .flush(flush),
        .OpCode(op), .Rsrc(rs[15:0]), .Rdest(rd[15:0]), .Out(out16),
        .out_valid(ov16), .Flags(fl16), .op_err(err16));

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy8), .flush(flush),
        .OpCode(op), .Rsrc(rs[7:0]), .Rdest(rd[7:0]), .Out(out8),
        .out_valid(ov8), .Flags(fl8), .op_err(err8));

    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy32), .flush(flush),
        .OpCode(op), .Rsrc(rs), .Rdest(rd), .Out(out32),
        .out_valid(ov32), .Flags(fl32), .op_err(err32));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int wid(input int s);
        return (s == 0) ? 16 : ((s == 1) ? 8 : 32);
    endfunction

    function automatic logic [31:0] g_out(input int s);
        return (s == 0) ? {16'h0, out16} : ((s == 1) ? {24'h0, out8} : out32);
    endfunction
    function automatic logic [31:0] g_ov(input int s);
        return {31'h0, (s == 0) ? ov16 : ((s == 1) ? ov8 : ov32)};
    endfunction
    function automatic logic [31:0] g_rdy(input int s);
        return {31'h0, (s == 0) ? rdy16 : ((s == 1) ? rdy8 : rdy32)};
    endfunction
    function automatic logic [31:0] g_err(input int s);
        return {31'h0, (s == 0) ? err16 : ((s == 1) ? err8 : err32)};
    endfunction
    function automatic logic [31:0] g_fl(input int s);
        return {27'h0, (s == 0) ? fl16 : ((s == 1) ? fl8 : fl32)};
    endfunction

    // Present one operation to instance s; returns at the negedge after the accept edge
    task automatic send(input int s, input logic [4:0] o, input logic [31:0] d, input logic [31:0] r);
        op = o; rd = d; rs = r;
        vld = 3'b000;
        vld[s] = 1'b1;
        $display("txn w%0d op=%0d rdest=%h rsrc=%h", wid(s), o, d, r);
        @(negedge clk);
        vld = 3'b000;
    endtask

    initial begin
        int w;
        logic [31:0] ones, msb, exp_v;
        int lat;
        logic seen_ov;

        rst_n = 1'b0; flush = 1'b0; vld = 3'b000; op = 5'd0; rd = '0; rs = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("w%0d reset out", wid(s)), g_out(s), 32'h0);
            check($sformatf("w%0d reset flags", wid(s)), g_fl(s), 32'h0);
            check($sformatf("w%0d reset ov", wid(s)), g_ov(s), 32'h0);
            check($sformatf("w%0d reset err", wid(s)), g_err(s), 32'h0);
            check($sformatf("w%0d reset rdy", wid(s)), g_rdy(s), 32'h1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            w    = wid(s);
            ones = 32'((64'h1 << w) - 64'h1);
            msb  = 32'h1 << (w - 1);

            // ADD most-negative + all-ones: wraps to max-positive, C=1, F=1, L=1,
            // and N=1 because most-negative < -1 as signed values.
            send(s, 5'd0, msb, ones);
            check($sformatf("w%0d add out", w), g_out(s), ones >> 1);
            check($sformatf("w%0d add ov", w), g_ov(s), 32'h1);
            check($sformatf("w%0d add flags", w), g_fl(s), 32'b10111);
            @(negedge clk);
            check($sformatf("w%0d add ov pulse", w), g_ov(s), 32'h0);

            // CMP equal operands: Z=1, N=L=0, F and C kept from the ADD
            send(s, 5'd2, 32'd5, 32'd5);
            check($sformatf("w%0d cmp flags", w), g_fl(s), 32'b01101);
            check($sformatf("w%0d cmp out kept", w), g_out(s), ones >> 1);
            check($sformatf("w%0d cmp ov", w), g_ov(s), 32'h1);
            @(negedge clk);

            // Carry chain: all-ones + 1 sets C, then ADDC 1+0+C = 2 clears it
            send(s, 5'd0, ones, 32'd1);
            check($sformatf("w%0d add carry out", w), g_out(s), 32'h0);
            check($sformatf("w%0d add carry flags", w), g_fl(s), 32'b10001);
            send(s, 5'd10, 32'd1, 32'd0);
            check($sformatf("w%0d addc out", w), g_out(s), 32'd2);
            check($sformatf("w%0d addc flags", w), g_fl(s), 32'b00000);
            @(negedge clk);

            // ARSHV by 4: busy 4 cycles, result on the fifth
            exp_v = ((msb | 32'h10) >> 4) | (ones & ~(ones >> 4));
            send(s, 5'd14, msb | 32'h10, 32'd4);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("w%0d arshv busy%0d rdy", w, i), g_rdy(s), 32'h0);
                check($sformatf("w%0d arshv busy%0d ov", w, i), g_ov(s), 32'h0);
                @(negedge clk);
            end
            check($sformatf("w%0d arshv ov", w), g_ov(s), 32'h1);
            check($sformatf("w%0d arshv out", w), g_out(s), exp_v);
            check($sformatf("w%0d arshv rdy", w), g_rdy(s), 32'h1);
            @(negedge clk);
            check($sformatf("w%0d arshv ov pulse", w), g_ov(s), 32'h0);
        end

        // SUB with borrow then SUBC consuming it (16-bit)
        send(0, 5'd1, 32'h0003, 32'h0005);
        check("w16 sub out", g_out(0), 32'hFFFE);
        check("w16 sub flags", g_fl(0), 32'b10011);
        send(0, 5'd11, 32'h0005, 32'h0003);
        check("w16 subc out", g_out(0), 32'h0001);
        check("w16 subc flags", g_fl(0), 32'b00000);

        // Flush of an RSHV by 9; in_valid while busy must be ignored
        send(0, 5'd0, 32'h8000, 32'hFFFF);
        check("w16 pre-flush out", g_out(0), 32'h7FFF);
        send(0, 5'd13, 32'hABCD, 32'd9);
        seen_ov = 1'b0;
        op = 5'd15; rs = 32'h5555; vld[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            seen_ov |= ov16;
            @(negedge clk);
        end
        flush = 1'b1;
        seen_ov |= ov16;
        @(negedge clk);
        flush = 1'b0;
        vld = 3'b000;
        check("w16 flush rdy", g_rdy(0), 32'h1);
        check("w16 flush out kept", g_out(0), 32'h7FFF);
        check("w16 flush flags kept", g_fl(0), 32'b10111);
        for (int i = 0; i < 12; i++) begin
            seen_ov |= ov16;
            @(negedge clk);
        end
        check("w16 flush no ov", {31'h0, seen_ov}, 32'h0);

        // Flush while idle does not block an accept
        flush = 1'b1;
        send(0, 5'd15, 32'h0, 32'h1234);
        flush = 1'b0;
        check("w16 idle flush mov out", g_out(0), 32'h1234);
        check("w16 idle flush mov ov", g_ov(0), 32'h1);

        // Variable shift amount 0 completes in one cycle
        send(0, 5'd12, 32'h00F0, 32'h0000);
        check("w16 lshv0 out", g_out(0), 32'h00F0);
        check("w16 lshv0 ov", g_ov(0), 32'h1);
        @(negedge clk);

        // Amount uses only the low 4 bits: 0x13 -> shift by 3
        send(0, 5'd12, 32'h00F0, 32'h0013);
        lat = 0;
        while (!ov16 && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check("w16 lshv3 latency", lat, 3);
        check("w16 lshv3 out", g_out(0), 32'h0780);
        @(negedge clk);

        // Single-bit shifts on back-to-back accepts
        send(0, 5'd9, 32'h0, 32'h8002);
        check("w16 arsh out", g_out(0), 32'hC001);
        send(0, 5'd8, 32'h0, 32'h8002);
        check("w16 rsh out", g_out(0), 32'h4001);
        send(0, 5'd7, 32'h0, 32'h8002);
        check("w16 lsh out", g_out(0), 32'h0004);

        // Logic ops, one accept per cycle: out_valid stays high every cycle
        send(0, 5'd3, 32'hF0F0, 32'hCC33);
        check("w16 and out", g_out(0), 32'hC030);
        check("w16 and ov", g_ov(0), 32'h1);
        send(0, 5'd4, 32'hF0F0, 32'hCC33);
        check("w16 or out", g_out(0), 32'hFCF3);
        check("w16 or ov", g_ov(0), 32'h1);
        send(0, 5'd5, 32'hF0F0, 32'hCC33);
        check("w16 xor out", g_out(0), 32'h3CC3);
        check("w16 xor ov", g_ov(0), 32'h1);
        send(0, 5'd6, 32'hF0F0, 32'hCC33);
        check("w16 not out", g_out(0), 32'h33CC);
        check("w16 not ov", g_ov(0), 32'h1);
        check("w16 logic flags kept", g_fl(0), 32'b10111);

        // Illegal opcode: error and valid pulse, state untouched
        send(0, 5'd20, 32'h1, 32'h2);
        check("w16 illegal err", g_err(0), 32'h1);
        check("w16 illegal ov", g_ov(0), 32'h1);
        check("w16 illegal out kept", g_out(0), 32'h33CC);
        check("w16 illegal flags kept", g_fl(0), 32'b10111);
        @(negedge clk);
        check("w16 illegal err pulse", g_err(0), 32'h0);

        // Asynchronous reset in the middle of an LSHV
        send(0, 5'd12, 32'h0001, 32'd10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("w16 async rst out", g_out(0), 32'h0);
        check("w16 async rst flags", g_fl(0), 32'h0);
        check("w16 async rst rdy", g_rdy(0), 32'h1);
        check("w16 async rst ov", g_ov(0), 32'h0);
        check("w32 async rst out", g_out(2), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
